// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   ILEN          instruction / address width
//   PC_STEP       byte distance between consecutive instruction words
//   fetch_entry_t {pc, word} pair held in the fetch buffer
//   align_pc      forces a PC onto a word boundary
package fetch_pkg;

  localparam int unsigned ILEN    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] word;
  } fetch_entry_t;

  function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] addr);
    return {addr[ILEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, word} entries.
//   clk, reset    clock and synchronous active-high reset
//   push_i        write push_data_i at the tail (ignored when full without a pop)
//   push_data_i   entry to write
//   pop_i         drop the head entry (ignored when empty)
//   flush_i       empty the FIFO; takes priority over push/pop
//   count_o       number of valid entries
//   head_o        head entry; all-zero storage after reset
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CntW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit: issues in-order word reads, buffers the returned words with their PCs
// and hands them to decode. A one-cycle redirect flushes everything and restarts at a new PC.
//   clk, reset                       clock, synchronous active-high reset
//   mem_req_valid/ready/addr         read request channel to instruction memory
//   mem_resp_valid/data              read response (always accepted, in order)
//   redirect, redirect_pc            flush-and-restart pulse from execute
//   instr_valid/ready, instr, instr_pc  decoded-side handshake
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]     pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d, drop_q, drop_d;
  logic [CntW-1:0] count;
  logic [CntW:0]   credits_used;
  logic            req_fire, push, pop;
  fetch_entry_t    push_entry, head;
  logic [$bits(fetch_entry_t)-1:0] head_raw;

  // Buffered plus in-flight entries never exceed DEPTH, so a push always finds room.
  assign credits_used  = {1'b0, inflight_q} + {1'b0, count};
  assign mem_req_valid = !reset && !redirect && (credits_used < (CntW + 1)'(DEPTH));
  assign mem_req_addr  = pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Responses to pre-redirect requests (including one landing in the redirect cycle) are dropped.
  assign push = mem_resp_valid && !redirect && (drop_q == '0);
  assign pop  = instr_valid && instr_ready && !redirect;

  assign push_entry = '{pc: resp_pc_q, word: mem_resp_data};
  assign head       = fetch_entry_t'(head_raw);

  assign instr_valid = !reset && (count != '0);
  assign instr       = reset ? '0 : head.word;
  assign instr_pc    = reset ? '0 : head.pc;

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (req_fire) begin
      pc_d       = pc_q + PC_STEP;
      inflight_d = inflight_d + CntW'(1);
    end
    if (mem_resp_valid) inflight_d = inflight_d - CntW'(1);
    if (redirect) begin
      pc_d      = align_pc(redirect_pc);
      resp_pc_d = align_pc(redirect_pc);
      // Every request still outstanding after this cycle belongs to the old stream.
      drop_d    = inflight_q - CntW'(mem_resp_valid);
    end else begin
      if (mem_resp_valid && (drop_q != '0)) drop_d = drop_q - CntW'(1);
      if (push) resp_pc_d = resp_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect),
    .count_o     (count),
    .head_o      (head_raw)
  );

  // A response with nothing outstanding means the memory broke the protocol.
  a_resp_has_request : assert property (@(posedge clk) disable iff (reset)
    !(mem_resp_valid && (inflight_q == '0)));

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid, mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b1;
  logic [31:0] instr, instr_pc;

  fetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Reference model: the fetch rules as plain counters and a queue.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;
  logic [31:0] m_pc = RESET_PC, m_resp_pc = RESET_PC;
  int          m_inflight = 0, m_drop = 0;
  ent_t        m_fifo[$];
  bit          m_ever = 1'b0;

  function automatic bit m_req_valid();
    return !reset && !redirect && ((m_inflight + int'(m_fifo.size())) < DEPTH);
  endfunction

  task automatic model_step();
    bit fire;
    if (reset) begin
      m_pc = RESET_PC; m_resp_pc = RESET_PC; m_inflight = 0; m_drop = 0;
      m_fifo.delete(); m_ever = 1'b0;
    end else begin
      fire = m_req_valid() && mem_req_ready;
      if (redirect) begin
        m_fifo.delete();
        m_pc = redirect_pc & ~32'h3;
        m_resp_pc = m_pc;
        m_inflight -= int'(mem_resp_valid);
        m_drop = m_inflight;
      end else begin
        if (m_fifo.size() != 0 && instr_ready) void'(m_fifo.pop_front());
        if (fire) begin m_pc += 32'd4; m_inflight++; end
        if (mem_resp_valid) begin
          m_inflight--;
          if (m_drop > 0) m_drop--;
          else begin
            m_fifo.push_back('{m_resp_pc, mem_resp_data});
            m_resp_pc += 32'd4;
            m_ever = 1'b1;
          end
        end
      end
    end
  endtask

  // Memory: fixed latency, in order, shares the reset.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t        memq[$];
  int          lat = 1;
  int          cyc = 0;
  bit          acc_q = 1'b0;
  logic [31:0] acc_addr = '0;

  always @(posedge clk) begin
    model_step();
    if (reset) memq.delete();
    else if (acc_q) memq.push_back('{acc_addr, cyc + lat});
    cyc++;
    #2;
    if (!reset && memq.size() != 0 && memq[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
  end

  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_word[$];

  // Per-cycle compare against the model, plus delivery capture.
  always @(negedge clk) begin
    bit ev;
    ev = m_req_valid();
    check("mem_req_valid", 32'(mem_req_valid), 32'(ev));
    if (ev) check("mem_req_addr", mem_req_addr, m_pc);
    if (reset) begin
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
    end else begin
      check("instr_valid", 32'(instr_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
        check("instr", instr, m_fifo[0].word);
        check("instr_pc", instr_pc, m_fifo[0].pc);
      end else if (!m_ever) begin
        check("idle_instr", instr, 32'd0);
        check("idle_instr_pc", instr_pc, 32'd0);
      end
    end
    acc_q    = mem_req_valid && mem_req_ready;
    acc_addr = mem_req_addr;
    if (instr_valid && instr_ready && !redirect && !reset) begin
      dlv_pc.push_back(instr_pc);
      dlv_word.push_back(instr);
    end
  end

  task automatic wait_dlv(input string name, output logic [31:0] pc, output logic [31:0] word);
    pc = 'x; word = 'x;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (dlv_pc.size() != 0) begin
        pc = dlv_pc.pop_front();
        word = dlv_word.pop_front();
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s timeout waiting for delivery", name);
  endtask

  task automatic expect_dlv(input string name, input logic [31:0] exp_pc,
                            input logic [31:0] exp_word);
    logic [31:0] p, w;
    wait_dlv(name, p, w);
    check({name, "_pc"}, p, exp_pc);
    check({name, "_word"}, w, exp_word);
  endtask

  task automatic pulse_redirect(input logic [31:0] npc);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = npc;
    dlv_pc.delete(); dlv_word.delete();
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  initial begin
    int found, got, exp_drop;
    logic [31:0] p, w;
    logic [31:0] acc_seen[2];

    // Reset and first request
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("first_req_valid", 32'(mem_req_valid), 32'd1);
    check("first_req_addr", mem_req_addr, 32'h0);

    // Sequential fetch at latency 1
    expect_dlv("seq0", 32'h0, 32'hFFFF_0000);
    expect_dlv("seq1", 32'h4, 32'hFFFB_0004);
    expect_dlv("seq2", 32'h8, 32'hFFF7_0008);
    repeat (10) @(posedge clk);

    // Backpressure: decode stalls at a known PC
    @(posedge clk); #1;
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (10) @(negedge clk);
    check("bp_req_valid", 32'(mem_req_valid), 32'd0);
    check("bp_instr_valid", 32'(instr_valid), 32'd1);
    check("bp_head_pc", instr_pc, 32'h80);
    check("bp_head_word", instr, 32'hFF7F_0080);
    @(posedge clk); #1;
    dlv_pc.delete(); dlv_word.delete();
    instr_ready = 1'b1;
    expect_dlv("bp0", 32'h80, 32'hFF7F_0080);
    expect_dlv("bp1", 32'h84, 32'hFF7B_0084);
    expect_dlv("bp2", 32'h88, 32'hFF77_0088);

    // Redirect with two requests pending at latency 3
    lat = 3;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(posedge clk); #1;
      if (m_inflight == 2) found = 1;
    end
    check("rd_two_pending", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h103;
    dlv_pc.delete(); dlv_word.delete();
    @(posedge clk); #1;
    redirect = 1'b0;
    expect_dlv("rd_first", 32'h100, 32'hFEFF_0100);
    expect_dlv("rd_next", 32'h104, 32'hFEFB_0104);

    // Redirect coinciding with a response and a pop
    lat = 2;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(posedge clk); #3;
      if (mem_resp_valid && instr_valid && instr_ready) begin
        exp_drop = m_inflight - 1;
        redirect = 1'b1; redirect_pc = 32'h200;
        dlv_pc.delete(); dlv_word.delete();
        found = 1;
      end
    end
    check("co_found", 32'(found), 32'd1);
    @(posedge clk); #1;
    redirect = 1'b0;
    check("co_drop", 32'(dut.drop_q), 32'(exp_drop));
    @(negedge clk);
    check("co_fifo_empty", 32'(instr_valid), 32'd0);
    expect_dlv("co_first", 32'h200, 32'hFDFF_0200);

    // PC wraps silently past the top of the address space
    lat = 1;
    pulse_redirect(32'hFFFF_FFF8);
    expect_dlv("wrap0", 32'hFFFF_FFF8, 32'h0007_FFF8);
    expect_dlv("wrap1", 32'hFFFF_FFFC, 32'h0003_FFFC);
    expect_dlv("wrap2", 32'h0000_0000, 32'hFFFF_0000);

    // Memory request stall: address holds, then advances by 4 per accept
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h300; mem_req_ready = 1'b0;
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_addr", mem_req_addr, 32'h300);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && got < 2; i++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        acc_seen[got] = mem_req_addr;
        got++;
      end
    end
    check("stall_acc_count", 32'(got), 32'd2);
    check("stall_acc0", acc_seen[0], 32'h300);
    check("stall_acc1", acc_seen[1], 32'h304);

    // Reset mid-stream once PC 0x40 has been delivered
    pulse_redirect(32'h30);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      wait_dlv("mid_seek", p, w);
      if (p == 32'h40) found = 1;
    end
    check("mid_reached_40", 32'(found), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dlv_pc.delete(); dlv_word.delete();
    expect_dlv("mid_after_reset", RESET_PC, 32'hFFFF_0000);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
